// File: rtl/div8_4_seq.sv
// Restoring divider: one quotient bit per clock, start/busy/done handshake, divide-by-zero flagged.
// Latency: accept edge N -> done high after edge N+WA+1 (N+1 for a zero divisor); start ignored outside IDLE.
module div8_4_seq #(
    parameter int WA = 8,
    parameter int WB = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WA-1:0] dividend,
    input  logic [WB-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [WA-1:0] quotient,
    output logic [WB-1:0] remainder,
    output logic          dbz
);

    localparam int CW = (WA > 1) ? $clog2(WA) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WA - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [WA-1:0] q_q;
    logic [WB-1:0] d_q;
    logic [WB-1:0] r_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [WA-1:0] quot_q;
    logic [WB-1:0] rem_q;
    logic          dbz_q;

    logic [WB:0]   step_t;
    logic          step_ge;
    logic [WA-1:0] q_d;
    logic [WB-1:0] r_d;

    // The extra remainder bit only lives in the trial value; after a restoring
    // step the remainder is always below the divisor and fits in WB bits.
    always_comb begin
        step_t  = {r_q, q_q[WA-1]};
        step_ge = (step_t >= {1'b0, d_q});
        r_d     = step_ge ? (step_t[WB-1:0] - d_q) : step_t[WB-1:0];
        q_d     = {q_q[WA-2:0], step_ge};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (divisor != '0) begin
                            q_q     <= dividend;
                            d_q     <= divisor;
                            r_q     <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            quot_q  <= '1;
                            rem_q   <= '0;
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        quot_q  <= q_d;
                        rem_q   <= r_d;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_div8_4_seq.sv
// Directed and exhaustive checks of div8_4_seq against a scoreboard of integer-division results.
module tb_div8_4_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, dbz;
    logic [7:0] quotient;
    logic [3:0] remainder;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    exp_t sb[$];

    div8_4_seq #(.WA(8), .WB(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dbz", dbz, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one accepted start pulse and records the expected result.
    task automatic start_op(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        e.a = a;
        e.b = b;
        if (bi == 0) begin
            e.q = 8'hFF; e.r = 4'd0; e.z = 1'b1;
        end else begin
            e.q = 8'(ai / bi); e.r = 4'(ai % bi); e.z = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done (bounded), then checks latency, busy time and the popped expectation.
    task automatic wait_result(input int lat, input int elapsed);
        exp_t e;
        int k, bz;
        k = elapsed;
        bz = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (busy === 1'b1) bz++;
        end
        chk("done_seen", done, 1);
        chk("latency", k, lat);
        if (elapsed == 0) chk("busy_cycles", bz, (lat == 1) ? 0 : 8);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("dbz", dbz, e.z);
            if (e.b != 0) begin
                chk("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                chk("rem_lt_div", (remainder < e.b) ? 1 : 0, 1);
            end
        end
        @(posedge clk);
        #1;
        chk("done_pulse", done, 0);
    endtask

    initial begin
        exp_t e;
        int k, first, second, ndone;
        do_reset();

        // Basic operation with reset between each
        start_op(8'd108, 4'd9);
        wait_result(9, 0);
        start_op(8'd28, 4'd4);  wait_result(9, 0); do_reset();
        start_op(8'd20, 4'd5);  wait_result(9, 0); do_reset();
        start_op(8'd24, 4'd3);  wait_result(9, 0); do_reset();
        start_op(8'd120, 4'd12); wait_result(9, 0); do_reset();

        // Same sequence back-to-back, then edge operands
        start_op(8'd28, 4'd4);  wait_result(9, 0);
        start_op(8'd20, 4'd5);  wait_result(9, 0);
        start_op(8'd24, 4'd3);  wait_result(9, 0);
        start_op(8'd120, 4'd12); wait_result(9, 0);
        start_op(8'd255, 4'd7); wait_result(9, 0);
        start_op(8'd3, 4'd15);  wait_result(9, 0);
        start_op(8'd255, 4'd1); wait_result(9, 0);
        start_op(8'd200, 4'd0); wait_result(1, 0);
        start_op(8'd100, 4'd10); wait_result(9, 0);

        // Results hold across accept; start and operand changes during RUN are ignored
        start_op(8'd108, 4'd9);
        chk("hold_quot", quotient, 10);
        chk("hold_busy", busy, 1);
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'd77; divisor = 4'd3;
        wait_result(9, 1);

        // Start held high: DONE ignores it, next accept follows ten cycles on
        @(negedge clk);
        start = 1'b1; dividend = 8'd28; divisor = 4'd4;
        e.a = 8'd28; e.b = 4'd4; e.q = 8'd7; e.r = 4'd0; e.z = 1'b0;
        sb.push_back(e);
        sb.push_back(e);
        k = 0; first = -1; second = -1;
        while (second < 0 && k < 60) begin
            @(posedge clk); #1;
            k++;
            if (done === 1'b1) begin
                if (first < 0) first = k; else second = k;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("b2b_quot", quotient, e.q);
                    chk("b2b_rem", remainder, e.r);
                end
            end
        end
        start = 1'b0;
        chk("b2b_first", first, 10);
        chk("b2b_spacing", second - first, 10);
        repeat (12) @(posedge clk);

        // Reset in the middle of RUN aborts with no done pulse
        start_op(8'd108, 4'd9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_quot", quotient, 0);
        chk("abort_rem", remainder, 0);
        chk("abort_dbz", dbz, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // Every operand pair
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(8'(a), 4'(b));
                wait_result((b == 0) ? 1 : 9, 0);
            end
        end

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
